// File: rtl/eth_frame_pkg.sv
// rtl/eth_frame_pkg.sv - shared constants, FSM state types and keep helper for the eth frame transactor
package eth_frame_pkg;

  localparam int ETH_HDR_BYTES = 14;
  localparam int ETH_HDR_W     = 112;

  localparam int ERR_SHORT = 0;
  localparam int ERR_LONG  = 1;
  localparam int ERR_TUSER = 2;

  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_PAY} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_PAY, RX_HOLD} rx_state_t;

  // Sized for the widest supported bus (512 bits = 64 keep lanes).
  function automatic logic [6:0] keep_popcount(input logic [63:0] keep);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + 7'(keep[i]);
    return n;
  endfunction

endpackage

// File: rtl/eth_frame_rx.sv
// rtl/eth_frame_rx.sv - RX FSM that collects a header plus payload beats into one flat frame
module eth_frame_rx
  import eth_frame_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int PAYLOAD_BYTES = 28,
  parameter int FRAME_W       = (ETH_HDR_BYTES + PAYLOAD_BYTES) * 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,
  output logic                  rx_frame_valid,
  input  logic                  rx_frame_ready,
  output logic [FRAME_W-1:0]    rx_frame_data,
  output logic [15:0]           rx_frame_len,
  output logic [2:0]            rx_frame_error
);

  localparam int PAY_W = PAYLOAD_BYTES * 8;

  rx_state_t         rx_state, rx_next;
  logic [47:0]       dest_q, src_q;
  logic [15:0]       type_q, cnt_q, cnt_next;
  logic [PAY_W-1:0]  pay_q;
  logic [2:0]        err_q, err_next;
  logic [6:0]        nkeep;
  logic [16:0]       cnt_sum;
  logic              hdr_fire, beat_fire;

  assign hdr_fire  = s_eth_hdr_valid && (rx_state == RX_IDLE);
  assign beat_fire = s_eth_payload_axis_tvalid && (rx_state == RX_PAY);
  assign nkeep     = keep_popcount(64'(s_eth_payload_axis_tkeep));
  assign cnt_sum   = {1'b0, cnt_q} + {10'b0, nkeep};
  assign cnt_next  = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  always_comb begin
    err_next            = '0;
    err_next[ERR_SHORT] = cnt_next < 16'(PAYLOAD_BYTES);
    err_next[ERR_LONG]  = cnt_next > 16'(PAYLOAD_BYTES);
    err_next[ERR_TUSER] = s_eth_payload_axis_tuser;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: if (s_eth_hdr_valid) rx_next = RX_PAY;
      RX_PAY:  if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tlast) rx_next = RX_HOLD;
      RX_HOLD: if (rx_frame_ready) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  // Each kept lane lands at byte position cnt+lane; positions past the buffer are only counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_q <= '0;
      src_q  <= '0;
      type_q <= '0;
      pay_q  <= '0;
      cnt_q  <= '0;
      err_q  <= '0;
    end else if (hdr_fire) begin
      dest_q <= s_eth_dest_mac;
      src_q  <= s_eth_src_mac;
      type_q <= s_eth_type;
      pay_q  <= '0;
      cnt_q  <= '0;
      err_q  <= '0;
    end else if (beat_fire) begin
      for (int k = 0; k < PAYLOAD_BYTES; k++)
        for (int i = 0; i < KEEP_WIDTH; i++)
          if (7'(i) < nkeep && ({1'b0, cnt_q} + 17'(i)) == 17'(k))
            pay_q[(PAYLOAD_BYTES-1-k)*8 +: 8] <= s_eth_payload_axis_tdata[8*i +: 8];
      cnt_q <= cnt_next;
      if (s_eth_payload_axis_tlast) err_q <= err_next;
    end
  end

  assign s_eth_hdr_ready           = rst_n && (rx_state == RX_IDLE);
  assign s_eth_payload_axis_tready = (rx_state == RX_PAY);
  assign rx_frame_valid            = (rx_state == RX_HOLD);
  assign rx_frame_data             = {dest_q, src_q, type_q, pay_q};
  assign rx_frame_len              = cnt_q;
  assign rx_frame_error            = err_q;

endmodule

// File: rtl/eth_frame_xfer.sv
// rtl/eth_frame_xfer.sv - flat frame <-> eth header + payload stream adapter (TX inline, RX sub-module)
module eth_frame_xfer
  import eth_frame_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int PAYLOAD_BYTES = 28,
  parameter int FRAME_W       = (ETH_HDR_BYTES + PAYLOAD_BYTES) * 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_frame_valid,
  output logic                  tx_frame_ready,
  input  logic [FRAME_W-1:0]    tx_frame_data,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,
  output logic                  rx_frame_valid,
  input  logic                  rx_frame_ready,
  output logic [FRAME_W-1:0]    rx_frame_data,
  output logic [15:0]           rx_frame_len,
  output logic [2:0]            rx_frame_error
);

  localparam int NB         = (PAYLOAD_BYTES + KEEP_WIDTH - 1) / KEEP_WIDTH;
  localparam int PAY_W      = PAYLOAD_BYTES * 8;
  localparam int PAD_W      = NB * DATA_WIDTH;
  localparam int LAST_BYTES = PAYLOAD_BYTES - (NB - 1) * KEEP_WIDTH;
  localparam logic [KEEP_WIDTH-1:0] LAST_KEEP = {KEEP_WIDTH{1'b1}} >> (KEEP_WIDTH - LAST_BYTES);

  tx_state_t        tx_state, tx_next;
  logic [PAD_W-1:0] pay_q;
  logic [15:0]      beat_q;
  logic             tx_last;

  assign tx_last = (beat_q == 16'(NB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (tx_frame_valid) tx_next = TX_HDR;
      TX_HDR:  if (m_eth_hdr_ready) tx_next = TX_PAY;
      TX_PAY:  if (m_eth_payload_axis_tready && tx_last) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  // Payload is left-aligned and zero-padded to whole beats, so the top lanes are always the next bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_eth_dest_mac <= '0;
      m_eth_src_mac  <= '0;
      m_eth_type     <= '0;
      pay_q          <= '0;
      beat_q         <= '0;
    end else if (tx_state == TX_IDLE && tx_frame_valid) begin
      m_eth_dest_mac <= tx_frame_data[FRAME_W-1 -: 48];
      m_eth_src_mac  <= tx_frame_data[FRAME_W-49 -: 48];
      m_eth_type     <= tx_frame_data[FRAME_W-97 -: 16];
      pay_q          <= PAD_W'(tx_frame_data[PAY_W-1:0]) << (PAD_W - PAY_W);
      beat_q         <= '0;
    end else if (tx_state == TX_PAY && m_eth_payload_axis_tready) begin
      pay_q  <= pay_q << DATA_WIDTH;
      beat_q <= beat_q + 16'd1;
    end
  end

  for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_lane
    assign m_eth_payload_axis_tdata[8*i +: 8] = pay_q[PAD_W-1-8*i -: 8];
  end

  assign tx_frame_ready            = rst_n && (tx_state == TX_IDLE);
  assign m_eth_hdr_valid           = (tx_state == TX_HDR);
  assign m_eth_payload_axis_tvalid = (tx_state == TX_PAY);
  assign m_eth_payload_axis_tlast  = (tx_state == TX_PAY) && tx_last;
  assign m_eth_payload_axis_tkeep  = (tx_state != TX_PAY) ? '0 : (tx_last ? LAST_KEEP : '1);
  assign m_eth_payload_axis_tuser  = 1'b0;

  eth_frame_rx #(
    .DATA_WIDTH   (DATA_WIDTH),
    .KEEP_WIDTH   (KEEP_WIDTH),
    .PAYLOAD_BYTES(PAYLOAD_BYTES),
    .FRAME_W      (FRAME_W)
  ) u_rx (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .s_eth_hdr_valid          (s_eth_hdr_valid),
    .s_eth_hdr_ready          (s_eth_hdr_ready),
    .s_eth_dest_mac           (s_eth_dest_mac),
    .s_eth_src_mac            (s_eth_src_mac),
    .s_eth_type               (s_eth_type),
    .s_eth_payload_axis_tdata (s_eth_payload_axis_tdata),
    .s_eth_payload_axis_tkeep (s_eth_payload_axis_tkeep),
    .s_eth_payload_axis_tvalid(s_eth_payload_axis_tvalid),
    .s_eth_payload_axis_tready(s_eth_payload_axis_tready),
    .s_eth_payload_axis_tlast (s_eth_payload_axis_tlast),
    .s_eth_payload_axis_tuser (s_eth_payload_axis_tuser),
    .rx_frame_valid           (rx_frame_valid),
    .rx_frame_ready           (rx_frame_ready),
    .rx_frame_data            (rx_frame_data),
    .rx_frame_len             (rx_frame_len),
    .rx_frame_error           (rx_frame_error)
  );

endmodule
